// File: rtl/crc_mem_pkg.sv
// Shared types for the CRC memory access scheduler: widths, FSM states,
// request sources and the latched operation record.
package crc_mem_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_SCRUB} src_t;

  typedef struct packed {
    src_t              src;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;
endpackage

// File: rtl/crc_mem_scrub_timer.sv
// Background scrub pacing: idle-cycle countdown, expiry flag and a wrapping
// scrub address pointer that advances each time a scrub completes.
module crc_mem_scrub_timer #(
  parameter int ADDR_W   = 4,
  parameter int INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tick,
  input  logic              i_reload,
  output logic              o_expired,
  output logic [ADDR_W-1:0] o_ptr
);
  localparam int CNT_W = $clog2(INTERVAL + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(INTERVAL);
      r_ptr <= '0;
    end else if (i_reload) begin
      r_cnt <= CNT_W'(INTERVAL);
      r_ptr <= r_ptr + 1'b1;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);
  assign o_ptr     = r_ptr;
endmodule

// File: rtl/crc_mem_scheduler.sv
// Shares the CRC-protected memory between hosts A/B and a background scrubber,
// sequences issue/wait/response and keeps CRC error statistics.
module crc_mem_scheduler import crc_mem_pkg::*; #(
  parameter int ADDR_W         = crc_mem_pkg::ADDR_W,
  parameter int DATA_W         = crc_mem_pkg::DATA_W,
  parameter int SCRUB_INTERVAL = 64,
  parameter int TIMEOUT        = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  input  logic              scrub_en,
  input  logic              err_clr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_completed,
  input  logic              mem_data_valid,
  input  logic              mem_error_detected,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              err_irq,
  output logic              timeout_flag
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  op_t               r_op;
  op_t               w_nxt;
  logic              r_last_b;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_pick_a, w_pick_b, w_pick_s;
  logic              w_scrub_exp, w_tick, w_reload;
  logic [ADDR_W-1:0] w_scrub_ptr;
  logic              w_crc_ev, w_to, w_own_a, w_own_b, w_rd_ok;

  // Round-robin between hosts; the scrubber only gets a fully idle bus.
  assign w_pick_a = a_req && (!b_req || r_last_b);
  assign w_pick_b = b_req && (!a_req || !r_last_b);
  assign w_pick_s = !a_req && !b_req && scrub_en && w_scrub_exp;

  assign w_tick   = (r_state == ST_IDLE) && scrub_en;
  assign w_reload = (r_state == ST_RESP) && (r_op.src == SRC_SCRUB);
  assign w_crc_ev = (r_state == ST_WAIT) && mem_completed && !r_op.we && mem_error_detected;
  assign w_to     = (r_state == ST_WAIT) && !mem_completed && (r_to_cnt == '0);
  assign w_own_a  = (r_op.src == SRC_A);
  assign w_own_b  = (r_op.src == SRC_B);
  assign w_rd_ok  = !r_op.we && mem_data_valid;

  assign mem_addr  = r_op.addr;
  assign mem_wdata = r_op.wdata;

  crc_mem_scrub_timer #(.ADDR_W(ADDR_W), .INTERVAL(SCRUB_INTERVAL)) u_scrub (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_tick),
    .i_reload  (w_reload),
    .o_expired (w_scrub_exp),
    .o_ptr     (w_scrub_ptr)
  );

  always_comb begin
    w_nxt = '0;
    if (w_pick_a) begin
      w_nxt.src = SRC_A; w_nxt.we = a_we; w_nxt.addr = a_addr; w_nxt.wdata = a_wdata;
    end else if (w_pick_b) begin
      w_nxt.src = SRC_B; w_nxt.we = b_we; w_nxt.addr = b_addr; w_nxt.wdata = b_wdata;
    end else begin
      w_nxt.src = SRC_SCRUB; w_nxt.addr = w_scrub_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE; r_op <= '0; r_last_b <= 1'b1; r_to_cnt <= '0;
      a_gnt <= 1'b0; b_gnt <= 1'b0; a_done <= 1'b0; b_done <= 1'b0;
      a_err <= 1'b0; b_err <= 1'b0; a_rdata <= '0; b_rdata <= '0;
      mem_write <= 1'b0; mem_read <= 1'b0; timeout_flag <= 1'b0;
    end else begin
      a_gnt <= 1'b0; b_gnt <= 1'b0; a_done <= 1'b0; b_done <= 1'b0;
      a_err <= 1'b0; b_err <= 1'b0; mem_write <= 1'b0; mem_read <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_pick_a || w_pick_b || w_pick_s) begin
          r_op      <= w_nxt;
          a_gnt     <= w_pick_a;
          b_gnt     <= w_pick_b;
          mem_write <= w_nxt.we;
          mem_read  <= !w_nxt.we;
          if (w_pick_a || w_pick_b) r_last_b <= w_pick_b;
          r_state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_to_cnt <= TO_W'(TIMEOUT);
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_completed) begin
            a_done <= w_own_a; b_done <= w_own_b;
            a_err  <= w_own_a && w_crc_ev;
            b_err  <= w_own_b && w_crc_ev;
            if (w_own_a && w_rd_ok) a_rdata <= mem_rdata;
            if (w_own_b && w_rd_ok) b_rdata <= mem_rdata;
            r_state <= ST_RESP;
          end else if (r_to_cnt == '0) begin
            a_done <= w_own_a; b_done <= w_own_b;
            a_err  <= w_own_a; b_err  <= w_own_b;
            timeout_flag <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // An error event in the same cycle as err_clr wins, leaving count=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0; last_err_addr <= '0; err_irq <= 1'b0;
    end else begin
      if (w_crc_ev) begin
        last_err_addr <= r_op.addr;
        if (err_clr)                err_count <= 8'd1;
        else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (err_clr) begin
        err_count <= '0;
      end
      if (w_crc_ev || w_to) err_irq <= 1'b1;
      else if (err_clr)     err_irq <= 1'b0;
    end
  end
endmodule

// File: tb/tb_crc_mem_scheduler.sv
// Directed bench: table of single host transactions plus hand sequences for
// arbitration, CRC error logging, saturation, timeout, scrubbing and reset.
module tb_crc_mem_scheduler;
  localparam int TO = 31;

  logic       clk, rst_n;
  logic       a_req, a_we, a_gnt, a_done, a_err;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_done, b_err;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       scrub_en, err_clr;
  logic       mem_write, mem_read, mem_completed, mem_data_valid, mem_error_detected;
  logic [3:0] mem_addr, last_err_addr;
  logic [7:0] mem_wdata, mem_rdata, err_count;
  logic       err_irq, timeout_flag;

  crc_mem_scheduler #(.ADDR_W(4), .DATA_W(8), .SCRUB_INTERVAL(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .scrub_en(scrub_en), .err_clr(err_clr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_completed(mem_completed), .mem_data_valid(mem_data_valid),
    .mem_error_detected(mem_error_detected), .mem_rdata(mem_rdata),
    .err_count(err_count), .last_err_addr(last_err_addr),
    .err_irq(err_irq), .timeout_flag(timeout_flag)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // Memory model: completes two cycles after the command; can withhold
  // completion or flip bits (fmask) and flag a CRC error on reads.
  logic [7:0] mem_arr [16];
  logic       m_pend, m_we, withhold, fault_en;
  logic [1:0] m_cnt;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, fmask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_cnt <= '0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      mem_completed <= 1'b0; mem_data_valid <= 1'b0; mem_error_detected <= 1'b0; mem_rdata <= '0;
    end else begin
      mem_completed <= 1'b0; mem_data_valid <= 1'b0; mem_error_detected <= 1'b0;
      if (mem_write || mem_read) begin
        m_pend <= 1'b1; m_cnt <= 2'd2; m_we <= mem_write; m_addr <= mem_addr; m_wdata <= mem_wdata;
      end else if (m_pend && !withhold) begin
        if (m_cnt > 2'd1) m_cnt <= m_cnt - 2'd1;
        else begin
          m_pend <= 1'b0; mem_completed <= 1'b1;
          if (m_we) mem_arr[m_addr] <= m_wdata;
          else begin
            mem_data_valid <= 1'b1;
            mem_rdata <= mem_arr[m_addr] ^ (fault_en ? fmask : 8'h00);
            mem_error_detected <= fault_en;
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_txn(input bit is_b, input bit we, input logic [3:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata, output logic err,
                          output int gw, output int lat, output bit cprev);
    int n;
    bit c;
    @(negedge clk);
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(is_b ? b_gnt : a_gnt) && n < 50);
    gw = n;
    a_req = 1'b0; b_req = 1'b0;
    chk("mem_cmd", {mem_write, mem_read, mem_addr}, {we, !we, addr});
    if (we) chk("mem_wdata", mem_wdata, wdata);
    n = 0; c = 1'b0;
    while (!(is_b ? b_done : a_done) && n < 100) begin
      c = mem_completed; @(negedge clk); n++;
    end
    lat = n; cprev = c;
    rdata = is_b ? b_rdata : a_rdata;
    err   = is_b ? b_err : a_err;
    chk("other_done", is_b ? a_done : b_done, 0);
  endtask

  typedef struct {
    bit         is_b;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] rd;
  logic       er;
  int         gw, lat, k, nrd, ngnt, a_dn, b_dn;
  bit         cp, seen_host;
  logic [3:0] exp_ptr, ord;

  initial begin
    vecs[0] = '{0, 1, 4'h0, 8'hA5, 8'h00};
    vecs[1] = '{0, 0, 4'h0, 8'h00, 8'hA5};
    vecs[2] = '{1, 1, 4'h1, 8'h3C, 8'h00};
    vecs[3] = '{1, 0, 4'h1, 8'h00, 8'h3C};
    vecs[4] = '{0, 1, 4'hF, 8'hFF, 8'h00};
    vecs[5] = '{1, 0, 4'hF, 8'h00, 8'hFF};
    vecs[6] = '{0, 1, 4'h7, 8'h5A, 8'h00};
    vecs[7] = '{1, 0, 4'h7, 8'h00, 8'h5A};

    rst_n = 1'b0; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; scrub_en = 0; err_clr = 0;
    withhold = 0; fault_en = 0; fmask = 8'h18;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata, a_err, b_err,
        mem_write, mem_read, mem_addr, mem_wdata, err_count, last_err_addr, err_irq, timeout_flag}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      host_txn(vecs[i].is_b, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, gw, lat, cp);
      chk("vec_gnt_latency", gw, 1);
      chk("vec_done_latency", lat, 4);
      chk("vec_done_after_completed", cp, 1);
      chk("vec_err", er, 0);
      if (!vecs[i].we) chk("vec_rdata", rd, vecs[i].exp_rd);
    end
    chk("no_errors_logged", {err_count, err_irq, timeout_flag}, 0);

    // Simultaneous requests, each port asking twice: A,B,A,B.
    host_txn(0, 1, 4'h2, 8'h11, rd, er, gw, lat, cp);
    host_txn(1, 1, 4'h3, 8'h22, rd, er, gw, lat, cp);
    @(negedge clk);
    a_we = 0; a_addr = 4'h2; b_we = 0; b_addr = 4'h3;
    a_req = 1; b_req = 1; a_dn = 0; b_dn = 0; ngnt = 0; ord = '0;
    for (int j = 0; j < 300 && (a_dn < 2 || b_dn < 2); j++) begin
      @(negedge clk);
      if (a_gnt) begin ord = {ord[2:0], 1'b0}; ngnt++; a_req = 0; end
      if (b_gnt) begin ord = {ord[2:0], 1'b1}; ngnt++; b_req = 0; end
      if (a_done && b_done) chk("both_done", 1, 0);
      if (a_done) begin a_dn++; chk("rr_a_rdata", a_rdata, 8'h11); if (a_dn < 2) a_req = 1; end
      if (b_done) begin b_dn++; chk("rr_b_rdata", b_rdata, 8'h22); if (b_dn < 2) b_req = 1; end
    end
    a_req = 0; b_req = 0;
    chk("rr_grants", ngnt, 4);
    chk("rr_order", ord, 4'b0101);

    // CRC error on B read of addr 1 (0x3C, bits 3..4 flipped).
    fault_en = 1;
    host_txn(1, 0, 4'h1, 8'h00, rd, er, gw, lat, cp);
    fault_en = 0;
    chk("crc_b_err", er, 1);
    chk("crc_b_rdata", rd, 8'h24);
    chk("crc_log", {err_count, last_err_addr, err_irq, timeout_flag}, {8'd1, 4'h1, 1'b1, 1'b0});
    @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;
    chk("err_clr", {err_count, err_irq}, 0);

    // Two errors, then a third coinciding with a held err_clr.
    fault_en = 1;
    host_txn(0, 0, 4'h1, 8'h00, rd, er, gw, lat, cp);
    chk("crc_a_err", er, 1);
    host_txn(0, 0, 4'h1, 8'h00, rd, er, gw, lat, cp);
    chk("err_count_2", err_count, 2);
    err_clr = 1;
    host_txn(1, 0, 4'h2, 8'h00, rd, er, gw, lat, cp);
    err_clr = 0;
    chk("clr_coincide", {err_count, last_err_addr, err_irq}, {8'd1, 4'h2, 1'b1});

    for (int j = 0; j < 260; j++) host_txn(1, 0, 4'h1, 8'h00, rd, er, gw, lat, cp);
    fault_en = 0;
    chk("err_count_saturate", err_count, 255);
    @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;
    chk("err_clr_after_sat", {err_count, err_irq}, 0);

    // Timeout: memory never completes.
    withhold = 1;
    host_txn(0, 0, 4'h0, 8'h00, rd, er, gw, lat, cp);
    withhold = 0;
    chk("timeout_latency", lat, TO + 2);
    chk("timeout_err", er, 1);
    chk("timeout_flags", {timeout_flag, err_irq, err_count}, {1'b1, 1'b1, 8'd0});
    host_txn(0, 0, 4'h0, 8'h00, rd, er, gw, lat, cp);
    chk("post_timeout_read", {rd, er}, {8'hA5, 1'b0});
    chk("post_timeout_latency", lat, 4);
    @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;
    chk("timeout_flag_sticky", {timeout_flag, err_irq}, {1'b1, 1'b0});

    // Scrubbing: addresses 0..15 then 0, with no host activity.
    scrub_en = 1; nrd = 0; k = 0; seen_host = 0; exp_ptr = '0;
    while (nrd < 17 && k < 2000) begin
      @(negedge clk); k++;
      if (mem_read) begin chk("scrub_addr", mem_addr, exp_ptr); exp_ptr = exp_ptr + 4'd1; nrd++; end
      if (a_done || b_done || a_gnt || b_gnt || mem_write) seen_host = 1;
    end
    chk("scrub_reads", nrd, 17);
    k = 0;
    while (!mem_completed && k < 50) begin @(negedge clk); k++; end
    chk("scrub_no_host_activity", seen_host, 0);
    host_txn(0, 0, 4'h0, 8'h00, rd, er, gw, lat, cp);
    scrub_en = 0;
    chk("host_beats_scrub", gw, 2);
    chk("host_beats_scrub_rd", {rd, er}, {8'hA5, 1'b0});

    // Asynchronous reset in the middle of WAIT.
    withhold = 1;
    @(negedge clk); a_req = 1; a_we = 0; a_addr = 4'h5;
    k = 0;
    do begin @(negedge clk); k++; end while (!a_gnt && k < 50);
    a_req = 0;
    chk("rst_test_gnt", a_gnt, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async_reset_outputs", {a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata, a_err, b_err,
        mem_write, mem_read, mem_addr, mem_wdata, err_count, last_err_addr, err_irq, timeout_flag}, 0);
    @(negedge clk); rst_n = 1; withhold = 0;
    host_txn(0, 0, 4'h0, 8'h00, rd, er, gw, lat, cp);
    chk("post_reset_gnt", gw, 1);
    chk("post_reset_read", {rd, er, lat[3:0]}, {8'hA5, 1'b0, 4'd4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
